// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshakes and optional iterative multiplier
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1,
  parameter int SH_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_result;
  logic              r_ovf;
  logic              r_out_valid;
  logic              r_busy;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [WIDTH-1:0]  r_acc;
  logic [SH_W-1:0]   r_cnt;

  logic [SH_W-1:0]         w_sh;
  logic [WIDTH-1:0]        w_sum;
  logic [WIDTH-1:0]        w_diff;
  logic signed [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0]        w_alu_res;
  logic                    w_alu_ovf;
  logic                    w_accept;
  logic                    w_use_mul;
  logic [WIDTH-1:0]        w_acc_next;
  logic                    w_last;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_use_mul = (MUL_EN != 0) && (alu_ctrl == OP_MUL);

  assign w_sh   = op2[SH_W-1:0];
  assign w_sum  = op1 + op2;
  assign w_diff = op1 - op2;
  assign w_sra  = $signed(op1) >>> w_sh;

  // MUL never reaches this decode when enabled, so it falls to the default (0) when MUL_EN=0
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (alu_ctrl)
      OP_AND:  w_alu_res = op1 & op2;
      OP_OR:   w_alu_res = op1 | op2;
      OP_XOR:  w_alu_res = op1 ^ op2;
      OP_NOR:  w_alu_res = ~(op1 | op2);
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (w_sum[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (w_diff[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLL:  w_alu_res = op1 << w_sh;
      OP_SRL:  w_alu_res = op1 >> w_sh;
      OP_SRA:  w_alu_res = w_sra;
      default: w_alu_res = '0;
    endcase
  end

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = (r_cnt == SH_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_use_mul) begin
              r_mcand     <= op1;
              r_mplier    <= op2;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
              r_state     <= S_MUL;
            end else begin
              r_result    <= w_alu_res;
              r_ovf       <= w_alu_ovf;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= w_acc_next;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result    = r_result;
  assign overflow  = r_ovf;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign zero      = (r_result == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - table-driven, scoreboarded bench for alu_seq
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [3:0]  alu_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;

  logic        u1_in_valid = 1'b0;
  logic        u1_in_ready;
  logic [31:0] u1_op1 = '0;
  logic [31:0] u1_op2 = '0;
  logic [3:0]  u1_alu_ctrl = '0;
  logic        u1_out_valid;
  logic [31:0] u1_result;
  logic        u1_zero;
  logic        u1_overflow;
  logic        u1_busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero),
    .overflow(overflow), .busy(busy)
  );

  alu_seq #(.WIDTH(32), .MUL_EN(0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .op1(u1_op1), .op2(u1_op2), .alu_ctrl(u1_alu_ctrl), .out_valid(u1_out_valid),
    .out_ready(1'b1), .result(u1_result), .zero(u1_zero),
    .overflow(u1_overflow), .busy(u1_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op, wait (bounded) for acceptance, and queue its expected output.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic eo, output int waits);
    op1 = a; op2 = b; alu_ctrl = c; in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!in_ready && waits <= 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits > 200) begin
      check("accept_timeout", 32'(waits), 32'd0);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back('{res: er, ovf: eo});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", result, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_result", result, e.res);
        check("sb_overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("sb_zero", {31'd0, zero}, {31'd0, (e.res == 32'd0)});
      end
    end
  end

  initial begin
    vec_t vt[$];
    int   w;
    int   tmo;

    vt.push_back('{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
    vt.push_back('{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
    vt.push_back('{4'b1011, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0});
    vt.push_back('{4'b1001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0});
    vt.push_back('{4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0});
    vt.push_back('{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0});
    vt.push_back('{4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0});
    vt.push_back('{4'b1100, 32'hFFFF_0000, 32'h0000_FF00, 32'h0000_00FF, 1'b0});
    vt.push_back('{4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
    vt.push_back('{4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1});
    vt.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
    vt.push_back('{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1});
    vt.push_back('{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0});
    vt.push_back('{4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vt.push_back('{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
    vt.push_back('{4'b1000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0});
    vt.push_back('{4'b1001, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0});
    vt.push_back('{4'b1010, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0});
    vt.push_back('{4'b1010, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0});
    vt.push_back('{4'b1011, 32'h4000_0000, 32'h0000_0001, 32'h2000_0000, 1'b0});
    vt.push_back('{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
    vt.push_back('{4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
    vt.push_back('{4'b1110, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0});

    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step();

    // ADD overflow into the sign bit, latency 1
    send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, w);
    check("add_latency", {31'd0, out_valid}, 32'd1);
    step();

    // SUB 5-5 held while consumer stalls
    out_ready = 1'b0;
    send(4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", result, 32'd0);
      check("hold_zero", {31'd0, zero}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back single-cycle ops: each must be accepted without a wait
    foreach (vt[i]) begin
      send(vt[i].ctrl, vt[i].a, vt[i].b, vt[i].res, vt[i].ovf, w);
      check("b2b_wait", 32'(w), 32'd0);
    end
    step();

    // MUL latency and busy window
    send(4'b1101, 32'h0001_0003, 32'h0000_0007, 32'h0007_0015, 1'b0, w);
    for (int i = 0; i < 32; i++) begin
      check("mul_busy", {31'd0, busy}, 32'd1);
      check("mul_in_ready", {31'd0, in_ready}, 32'd0);
      check("mul_out_valid", {31'd0, out_valid}, 32'd0);
      step();
    end
    check("mul_done_valid", {31'd0, out_valid}, 32'd1);
    check("mul_done_busy", {31'd0, busy}, 32'd0);
    step();

    send(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, w);
    send(4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, w);
    check("post_mul_wait", 32'(w), 32'd32);
    send(4'b1101, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, w);
    send(4'b1101, 32'h0000_0013, 32'h0000_000B, 32'h0000_00D1, 1'b0, w);
    tmo = 0;
    while (exp_q.size() != 0 && tmo < 200) begin
      step();
      tmo++;
    end
    check("drain_mul", 32'(exp_q.size()), 32'd0);
    step();

    // Reset during the 10th multiplier iteration discards the op
    send(4'b1101, 32'h0000_0005, 32'h0000_0006, 32'd30, 1'b0, w);
    repeat (10) step();
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("midrst_no_output", {31'd0, out_valid}, 32'd0);
    send(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, w);
    check("post_rst_latency", {31'd0, out_valid}, 32'd1);
    step();

    // MUL opcode on a build without the multiplier
    u1_op1 = 32'd3; u1_op2 = 32'd7; u1_alu_ctrl = 4'b1101; u1_in_valid = 1'b1;
    @(negedge clk);
    check("nomul_in_ready", {31'd0, u1_in_ready}, 32'd1);
    step();
    u1_in_valid = 1'b0;
    check("nomul_out_valid", {31'd0, u1_out_valid}, 32'd1);
    check("nomul_result", u1_result, 32'd0);
    check("nomul_zero", {31'd0, u1_zero}, 32'd1);
    check("nomul_overflow", {31'd0, u1_overflow}, 32'd0);
    check("nomul_busy", {31'd0, u1_busy}, 32'd0);
    step();

    tmo = 0;
    while (exp_q.size() != 0 && tmo < 50) begin
      step();
      tmo++;
    end
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath's combinational ALU.
- Adds valid/ready handshakes on input and output, a configurable width, and shift, XOR and signed-compare operations.
- Adds an optional iterative shift-add multiplier that takes WIDTH cycles.
- Sits between decode/issue and writeback; results are held in an output register until the consumer accepts them.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of two)
MUL_EN, 1, 1 = implement MUL opcode; 0 = MUL opcode decodes as default (result 0, latency 1)
SH_W, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk        in   1      clock, all state on rising edge
rst        in   1      asynchronous, active-high reset
in_valid   in   1      operation presented
in_ready   out  1      block can accept an operation this cycle
op1        in   WIDTH  operand A
op2        in   WIDTH  operand B (shift amount = op2[SH_W-1:0])
alu_ctrl   in   4      opcode
out_valid  out  1      result register holds an unconsumed result
out_ready  in   1      consumer accepts result
result     out  WIDTH  registered result
zero       out  1      (result == 0), derived from registered result
overflow   out  1      registered signed overflow (ADD/SUB only, else 0)
busy       out  1      multiplier iterating

Behaviour:
- Opcode map:
  - Existing encodings are unchanged: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLTU (unsigned, result 1/0), 1100 NOR.
  - New: 0011 XOR, 1000 SLT (signed, result 1/0), 1001 SLL, 1010 SRL, 1011 SRA (arithmetic), 1101 MUL (low WIDTH bits of unsigned product).
  - Any other opcode: result 0, overflow 0.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
  - overflow = signed overflow: for ADD, operand signs equal and the sum sign differs; for SUB, operand signs differ and the difference sign differs from op1.
- Shifts: amount op2[SH_W-1:0]; upper op2 bits ignored; amount 0 returns op1.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid:
    - MUL with MUL_EN=1: latch operands, clear accumulator, counter=0, go to MUL.
    - Otherwise: compute, load result/overflow, go to DONE (latency 1 cycle).
  - MUL: in_ready=0, busy=1. Each cycle: if multiplier LSB=1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
    - After exactly WIDTH iterations, load result=acc and overflow=0, then go to DONE.
    - Accept-to-out_valid latency is WIDTH+1 cycles.
  - DONE: out_valid=1; result/overflow held stable while out_valid=1 and out_ready=0.
    - out_ready=1 and in_valid=1: accept the new op in the same cycle (in_ready = out_ready in DONE). Single-cycle op stays in DONE with new result; MUL goes to MUL.
    - out_ready=1 and in_valid=0: go to IDLE, out_valid drops next cycle.
- Throughput: one single-cycle op per clock under continuous out_ready=1.
- Inputs are sampled only on the accept edge (in_valid & in_ready); later changes to op1/op2/alu_ctrl have no effect.
- in_valid while in_ready=0: ignored; upstream must hold it.
- Reset (asynchronous, any state including mid-MUL):
  - state IDLE, out_valid 0, result 0, zero 1, overflow 0, busy 0, in_ready 1.
  - Counter and accumulator cleared; any in-flight op is discarded with no output.
- zero and overflow are meaningful only while out_valid=1.

Test Plan:
- Reset then ADD 0x7FFFFFFF+0x00000001 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0.
- SUB 5-5 with out_ready=0 for 3 cycles -> result=0, zero=1 held stable, in_ready=0; out_ready=1 -> out_valid drops next cycle.
- Back-to-back with out_ready=1: SLT(0xFFFFFFFF,1), SLTU(0xFFFFFFFF,1), SRA(0x80000000,op2=0x24), SLL(1,31), XOR(0xF0F0F0F0,0xFFFF0000) -> one result per cycle: 1, 0, 0xF8000000, 0x80000000, 0x0F0FF0F0.
- MUL 0x0001_0003 x 0x0000_0007 -> busy=1 for 32 cycles, in_ready=0 throughout, out_valid after 33 cycles, result=0x0007_0015, overflow=0.
- Assert rst at iteration 10 of a MUL -> immediately out_valid=0, busy=0, result=0; a following ADD 2+3 returns 5 after 1 cycle.
- Opcode 1111 and MUL_EN=0 build with opcode 1101 -> result 0, zero=1, overflow=0, latency 1.
